// File: rtl/fault_frame_encoder_if.sv
// fault_frame_encoder_if
//   Bundles the payload handshake, the fault-injection controls and the
//   encoded frame / self-test counters of fault_frame_encoder.
//   master : payload source / frame consumer (drives in_* and inj_*)
//   slave  : the encoder (drives in_ready, r0, check, out_valid, counters)
//   Signals:
//     in_valid, in_ready, in_data[7:0]      payload handshake
//     inj_en, inj_sel[2:0], inj_double      fault-injection request
//     r0[7:0], check[1:0], out_valid        transmitted frame
//     frame_cnt[7:0], fault_cnt[7:0]        self-test counters
interface fault_frame_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       inj_en;
  logic [2:0] inj_sel;
  logic       inj_double;
  logic [7:0] r0;
  logic [1:0] check;
  logic       out_valid;
  logic [7:0] frame_cnt;
  logic [7:0] fault_cnt;

  modport master (
    output in_valid, in_data, inj_en, inj_sel, inj_double,
    input  in_ready, r0, check, out_valid, frame_cnt, fault_cnt
  );

  modport slave (
    input  in_valid, in_data, inj_en, inj_sel, inj_double,
    output in_ready, r0, check, out_valid, frame_cnt, fault_cnt
  );
endinterface

// File: rtl/fault_frame_encoder.sv
// fault_frame_encoder
//   Transmit-side frame generator for the fault-protection checkers. Accepts
//   an 8-bit payload, computes a 2-bit check field from the clean payload,
//   optionally flips one or two data bits, and holds the resulting r0/check
//   frame for HOLD_CYCLES cycles followed by GAP_CYCLES idle cycles.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous active-low reset
//     bus    : fault_frame_encoder_if.slave (handshake, injection, frame,
//              frame/fault counters)
module fault_frame_encoder #(
  parameter int HOLD_CYCLES = 4,  // 1..255
  parameter int GAP_CYCLES  = 2   // 0..255
) (
  input  logic                  clk,
  input  logic                  reset,
  fault_frame_encoder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    DRIVE  = 2'd2,
    GAP    = 2'd3
  } state_t;

  // Counters are preloaded with N-1 and the phase ends on the edge seen at 0,
  // so each phase lasts exactly N cycles. GAP_LOAD is unused when GAP_CYCLES=0.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_t     state_reg, state_next;
  logic       in_ready_reg, in_ready_next;
  logic       out_valid_reg, out_valid_next;
  logic [7:0] r0_reg, r0_next;
  logic [1:0] check_reg, check_next;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic [7:0] fault_cnt_reg, fault_cnt_next;
  logic [7:0] phase_cnt_reg, phase_cnt_next;

  // Captured payload and injection request (held from accept to ENCODE).
  logic [7:0] data_reg, data_next;
  logic       inj_en_reg, inj_en_next;
  logic [2:0] inj_sel_reg, inj_sel_next;
  logic       inj_double_reg, inj_double_next;

  // Flip mask: bit inj_sel, plus its neighbour (wrapping 7 -> 0) when double.
  logic [2:0] inj_sel_plus1;
  logic [7:0] inj_mask;

  assign inj_sel_plus1 = inj_sel_reg + 3'd1;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      assign inj_mask[gi] = inj_en_reg &
                            ((inj_sel_reg == 3'(gi)) |
                             (inj_double_reg & (inj_sel_plus1 == 3'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      r0_reg         <= 8'd0;
      check_reg      <= 2'd0;
      frame_cnt_reg  <= 8'd0;
      fault_cnt_reg  <= 8'd0;
      phase_cnt_reg  <= 8'd0;
      data_reg       <= 8'd0;
      inj_en_reg     <= 1'b0;
      inj_sel_reg    <= 3'd0;
      inj_double_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      in_ready_reg   <= in_ready_next;
      out_valid_reg  <= out_valid_next;
      r0_reg         <= r0_next;
      check_reg      <= check_next;
      frame_cnt_reg  <= frame_cnt_next;
      fault_cnt_reg  <= fault_cnt_next;
      phase_cnt_reg  <= phase_cnt_next;
      data_reg       <= data_next;
      inj_en_reg     <= inj_en_next;
      inj_sel_reg    <= inj_sel_next;
      inj_double_reg <= inj_double_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    in_ready_next   = in_ready_reg;
    out_valid_next  = out_valid_reg;
    r0_next         = r0_reg;
    check_next      = check_reg;
    frame_cnt_next  = frame_cnt_reg;
    fault_cnt_next  = fault_cnt_reg;
    phase_cnt_next  = phase_cnt_reg;
    data_next       = data_reg;
    inj_en_next     = inj_en_reg;
    inj_sel_next    = inj_sel_reg;
    inj_double_next = inj_double_reg;

    case (state_reg)
      IDLE: begin
        // in_ready rises on the first edge spent in IDLE (e.g. after reset).
        in_ready_next = 1'b1;
        if (bus.in_valid && in_ready_reg) begin
          data_next       = bus.in_data;
          inj_en_next     = bus.inj_en;
          inj_sel_next    = bus.inj_sel;
          inj_double_next = bus.inj_double;
          in_ready_next   = 1'b0;
          state_next      = ENCODE;
        end
      end

      ENCODE: begin
        // check is derived from the clean payload, never from r0.
        r0_next        = data_reg ^ inj_mask;
        check_next     = {^data_reg[3:0], ^data_reg};
        out_valid_next = 1'b1;
        frame_cnt_next = frame_cnt_reg + 8'd1;
        if (inj_en_reg && (fault_cnt_reg != 8'hFF)) begin
          fault_cnt_next = fault_cnt_reg + 8'd1;
        end
        phase_cnt_next = HOLD_LOAD;
        state_next     = DRIVE;
      end

      DRIVE: begin
        if (phase_cnt_reg == 8'd0) begin
          out_valid_next = 1'b0;
          if (GAP_CYCLES > 0) begin
            phase_cnt_next = GAP_LOAD;
            state_next     = GAP;
          end else begin
            in_ready_next = 1'b1;
            state_next    = IDLE;
          end
        end else begin
          phase_cnt_next = phase_cnt_reg - 8'd1;
        end
      end

      GAP: begin
        if (phase_cnt_reg == 8'd0) begin
          in_ready_next = 1'b1;
          state_next    = IDLE;
        end else begin
          phase_cnt_next = phase_cnt_reg - 8'd1;
        end
      end

      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
        in_ready_next  = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.r0        = r0_reg;
  assign bus.check     = check_reg;
  assign bus.frame_cnt = frame_cnt_reg;
  assign bus.fault_cnt = fault_cnt_reg;

endmodule
